// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bundle: decoded instruction, forwarding sources and hazard controls in,
// registered ALU operands and write-back control out.
interface id_ex_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  InValid;
    logic                  Stall;
    logic                  Flush;
    logic [31:0]           Instr;
    logic [XLEN-1:0]       PC;
    logic [XLEN-1:0]       RD1;
    logic [XLEN-1:0]       RD2;
    logic [XLEN-1:0]       Imm;
    logic [REG_ADDR_W-1:0] ExMemRd;
    logic                  ExMemRegWrite;
    logic [XLEN-1:0]       ExMemResult;
    logic [REG_ADDR_W-1:0] MemWbRd;
    logic                  MemWbRegWrite;
    logic [XLEN-1:0]       MemWbResult;

    logic [XLEN-1:0]       A;
    logic [XLEN-1:0]       B;
    logic [3:0]            ALUControl;
    logic [XLEN-1:0]       StoreData;
    logic [REG_ADDR_W-1:0] RdOut;
    logic                  RegWriteOut;
    logic                  OutValid;
    logic                  IllegalInstr;

    modport master (
        output InValid, Stall, Flush, Instr, PC, RD1, RD2, Imm,
               ExMemRd, ExMemRegWrite, ExMemResult, MemWbRd, MemWbRegWrite, MemWbResult,
        input  A, B, ALUControl, StoreData, RdOut, RegWriteOut, OutValid, IllegalInstr
    );

    modport slave (
        input  InValid, Stall, Flush, Instr, PC, RD1, RD2, Imm,
               ExMemRd, ExMemRegWrite, ExMemResult, MemWbRd, MemWbRegWrite, MemWbResult,
        output A, B, ALUControl, StoreData, RdOut, RegWriteOut, OutValid, IllegalInstr
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU control, resolves operand forwarding and
// registers everything so the ALU is fed straight from flops during EX.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_ADDR_W-1:0] rd, rs1, rs2;
    logic [XLEN-1:0]       fwd_a, fwd_b;

    logic [XLEN-1:0]       nxt_a, nxt_b;
    logic [3:0]            nxt_ctrl;
    logic                  nxt_regw, nxt_illegal;

    logic [XLEN-1:0]       a_q, b_q, store_q;
    logic [3:0]            ctrl_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  regw_q, valid_q, illegal_q;

    assign opcode = bus.Instr[6:0];
    assign funct3 = bus.Instr[14:12];
    assign funct7 = bus.Instr[31:25];
    assign rd     = bus.Instr[7 +: REG_ADDR_W];
    assign rs1    = bus.Instr[15 +: REG_ADDR_W];
    assign rs2    = bus.Instr[20 +: REG_ADDR_W];

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    // EX/MEM is the younger producer, so it is checked first; x0 never forwards.
    always_comb begin
        fwd_a = bus.RD1;
        if (bus.ExMemRegWrite && bus.ExMemRd != '0 && bus.ExMemRd == rs1)
            fwd_a = bus.ExMemResult;
        else if (bus.MemWbRegWrite && bus.MemWbRd != '0 && bus.MemWbRd == rs1)
            fwd_a = bus.MemWbResult;

        fwd_b = bus.RD2;
        if (bus.ExMemRegWrite && bus.ExMemRd != '0 && bus.ExMemRd == rs2)
            fwd_b = bus.ExMemResult;
        else if (bus.MemWbRegWrite && bus.MemWbRd != '0 && bus.MemWbRd == rs2)
            fwd_b = bus.MemWbResult;
    end

    always_comb begin
        nxt_a       = '0;
        nxt_b       = '0;
        nxt_ctrl    = ALU_ADD;
        nxt_regw    = 1'b0;
        nxt_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                nxt_a    = fwd_a;
                nxt_b    = fwd_b;
                nxt_regw = 1'b1;
                nxt_ctrl = alu_op(funct3, funct7[5]);
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    nxt_illegal = 1'b1;
            end
            OP_I: begin
                nxt_a    = fwd_a;
                nxt_b    = bus.Imm;
                nxt_regw = 1'b1;
                // Instr[30] is immediate data for ADDI; only shifts use it as SRA select.
                nxt_ctrl = alu_op(funct3, (funct3 == 3'b101) && bus.Instr[30]);
            end
            OP_LOAD, OP_STORE: begin
                nxt_a    = fwd_a;
                nxt_b    = bus.Imm;
                nxt_regw = (opcode == OP_LOAD);
            end
            OP_BR: begin
                nxt_a    = fwd_a;
                nxt_b    = fwd_b;
                nxt_ctrl = ALU_SUB;
            end
            OP_LUI: begin
                nxt_b    = bus.Imm;
                nxt_regw = 1'b1;
            end
            OP_AUIPC: begin
                nxt_a    = bus.PC;
                nxt_b    = bus.Imm;
                nxt_regw = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                nxt_a    = bus.PC;
                nxt_b    = XLEN'(4);
                nxt_regw = 1'b1;
            end
            default: nxt_illegal = 1'b1;
        endcase

        if (nxt_illegal) begin
            nxt_a    = '0;
            nxt_b    = '0;
            nxt_ctrl = ALU_ADD;
            nxt_regw = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.Flush) begin
            a_q       <= '0;
            b_q       <= '0;
            store_q   <= '0;
            ctrl_q    <= ALU_ADD;
            rd_q      <= '0;
            regw_q    <= 1'b0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!bus.Stall) begin
            a_q       <= nxt_a;
            b_q       <= nxt_b;
            store_q   <= fwd_b;
            ctrl_q    <= nxt_ctrl;
            rd_q      <= rd;
            regw_q    <= nxt_regw && bus.InValid && (rd != '0);
            valid_q   <= bus.InValid;
            illegal_q <= nxt_illegal;
        end
    end

    assign bus.A            = a_q;
    assign bus.B            = b_q;
    assign bus.StoreData    = store_q;
    assign bus.ALUControl   = ctrl_q;
    assign bus.RdOut        = rd_q;
    assign bus.RegWriteOut  = regw_q;
    assign bus.OutValid     = valid_q;
    assign bus.IllegalInstr = illegal_q;
endmodule
